// File: rtl/streamer_pkg.sv
// streamer_pkg: shared types and default sizes for the operand streamer.
package streamer_pkg;

  localparam int PKG_DATA_W       = 8;
  localparam int PKG_NUM_OPERANDS = 10;

  // Run sequencing: processor reset, operand stream, compute wait, result hold.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRST,
    ST_STREAM,
    ST_COMPUTE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/operand_streamer_if.sv
// operand_streamer_if: host write port, run control, processor link and result
// port of the operand streamer. The host/harness side uses the master modport,
// the streamer uses the slave modport.
// Optional checksum signal present when OPERAND_STREAMER_CHECKSUM_EN is defined.
interface operand_streamer_if
  import streamer_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W
);

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              start;
  logic              busy;
  logic              err;
  logic              proc_reset;
  logic [DATA_W-1:0] next_in;
  logic [DATA_W-1:0] f;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;
`ifdef OPERAND_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    output wr_data, wr_valid, start, f, result_ready,
    input  wr_ready, busy, err, proc_reset, next_in, result, result_valid, checksum
  );

  modport slave (
    input  wr_data, wr_valid, start, f, result_ready,
    output wr_ready, busy, err, proc_reset, next_in, result, result_valid, checksum
  );
`else
  modport master (
    output wr_data, wr_valid, start, f, result_ready,
    input  wr_ready, busy, err, proc_reset, next_in, result, result_valid
  );

  modport slave (
    input  wr_data, wr_valid, start, f, result_ready,
    output wr_ready, busy, err, proc_reset, next_in, result, result_valid
  );
`endif

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word data visible at the output.
// DEPTH must be a power of two so pointers wrap naturally. Push is refused
// when full (no same-cycle pass-through); pop is ignored when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_streamer.sv
// operand_streamer: buffers host operand bytes, then on start resets the
// vector processor, streams NUM_OPERANDS bytes on next_in, waits
// COMPUTE_CYCLES, captures f and offers it on a valid/ready result port.
// Optional feature macro: OPERAND_STREAMER_CHECKSUM_EN adds a running
// modulo-2^DATA_W checksum of the bytes streamed in the current/last run.
module operand_streamer
  import streamer_pkg::*;
#(
  parameter int DATA_W         = PKG_DATA_W,
  parameter int NUM_OPERANDS   = PKG_NUM_OPERANDS,
  parameter int FIFO_DEPTH     = 16,
  parameter int COMPUTE_CYCLES = 12
) (
  input logic               clk,
  input logic               reset,
  operand_streamer_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(NUM_OPERANDS + 1);
  localparam int CC_W  = $clog2(COMPUTE_CYCLES + 1);

  localparam logic [SC_W-1:0]  LAST_STREAM  = SC_W'(NUM_OPERANDS - 1);
  localparam logic [CC_W-1:0]  COMPUTE_LOAD = CC_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_NEED     = CNT_W'(NUM_OPERANDS);

  state_t            state;
  logic [SC_W-1:0]   stream_cnt;
  logic [CC_W-1:0]   compute_cnt;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              start_ok;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_valid),
    .push_data (bus.wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // next_in is registered, so each byte is popped one cycle ahead of its
  // STREAM slot: in PRST for byte 0, in STREAM cycle k for byte k+1.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_PRST) ||
                     ((state == ST_STREAM) && (stream_cnt != LAST_STREAM)));

  assign start_ok       = (fifo_count >= RUN_NEED);
  assign bus.wr_ready   = !fifo_full;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.proc_reset = reset | (state == ST_PRST);

  // Run sequencer with registered next_in, err pulse and result port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      stream_cnt       <= '0;
      compute_cnt      <= '0;
      bus.next_in      <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (start_ok) state   <= ST_PRST;
            else          bus.err <= 1'b1;
          end
        end
        ST_PRST: begin
          bus.next_in <= fifo_head;
          stream_cnt  <= '0;
          state       <= ST_STREAM;
        end
        ST_STREAM: begin
          if (stream_cnt == LAST_STREAM) begin
            bus.next_in <= '0;
            compute_cnt <= COMPUTE_LOAD;
            state       <= ST_COMPUTE;
          end else begin
            bus.next_in <= fifo_head;
            stream_cnt  <= stream_cnt + 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (compute_cnt == '0) begin
            bus.result       <= bus.f;
            bus.result_valid <= 1'b1;
            state            <= ST_HOLD;
          end else begin
            compute_cnt <= compute_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OPERAND_STREAMER_CHECKSUM_EN
  // Checksum clears at PRST, adds each streamed byte, holds until next run.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_PRST)) begin
      bus.checksum <= '0;
    end else if (state == ST_STREAM) begin
      bus.checksum <= bus.checksum + bus.next_in;
    end
  end
`endif

endmodule

// File: tb/tb_operand_streamer.sv
// tb_operand_streamer: scenario tasks against a queue-based reference model.
// The model keeps the FIFO contents as a queue; each run expects the oldest
// NUM_OPERANDS bytes on next_in and the spec's fixed cycle offsets.
module tb_operand_streamer;

  localparam int N     = 10;
  localparam int C     = 12;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  int tests_run;
  int tests_failed;

  logic [7:0] model_q[$];

  operand_streamer_if #(.DATA_W(8)) bus ();

  operand_streamer #(
    .DATA_W         (8),
    .NUM_OPERANDS   (N),
    .FIFO_DEPTH     (DEPTH),
    .COMPUTE_CYCLES (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; the model accepts it only if it holds fewer than DEPTH.
  task automatic push_byte(input logic [7:0] b);
    logic exp_ready;
    exp_ready    = (model_q.size() < DEPTH);
    bus.wr_data  = b;
    bus.wr_valid = 1'b1;
    tests_run++;
    if (bus.wr_ready !== exp_ready) begin
      tests_failed++;
      $display("FAIL push_wr_ready: got %b expected %b (model count %0d)",
               bus.wr_ready, exp_ready, model_q.size());
    end
    if (exp_ready) model_q.push_back(b);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic check_count(input string tag);
    tests_run++;
    if (int'(dut.u_fifo.count) !== model_q.size()) begin
      tests_failed++;
      $display("FAIL %s fifo_count: got %0d expected %0d", tag, dut.u_fifo.count, model_q.size());
    end
  endtask

  // Full run starting in an IDLE cycle.
  task automatic do_run(input logic [7:0] fval, input int ready_delay,
                        input bit concurrent, input string tag);
    logic [7:0] exp_bytes[$];
    logic [7:0] sum;
    int         start_count;
    bit         conc;
    start_count = model_q.size();
    conc        = concurrent && (start_count <= 12);
    sum         = '0;
    for (int i = 0; i < N; i++) begin
      exp_bytes.push_back(model_q.pop_front());
      sum = sum + exp_bytes[i];
    end
    bus.f     = fval ^ 8'h5A;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run++;
    if (bus.proc_reset !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s prst: proc_reset=%b busy=%b expected 1 1", tag, bus.proc_reset, bus.busy);
    end
    tests_run++;
    if (bus.wr_ready !== (start_count < DEPTH)) begin
      tests_failed++;
      $display("FAIL %s prst_wr_ready: got %b expected %b", tag, bus.wr_ready, start_count < DEPTH);
    end
    for (int k = 0; k < N; k++) begin
      if (conc) begin
        bus.wr_data  = 8'($urandom);
        bus.wr_valid = 1'b1;
        tests_run++;
        if (bus.wr_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s conc_wr_ready: got %b expected 1", tag, bus.wr_ready);
        end else begin
          model_q.push_back(bus.wr_data);
        end
      end
      tick();
      bus.wr_valid = 1'b0;
      tests_run++;
      if (bus.next_in !== exp_bytes[k] || bus.proc_reset !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s stream[%0d]: next_in=%h proc_reset=%b expected %h 0",
                 tag, k, bus.next_in, bus.proc_reset, exp_bytes[k]);
      end
      if (k == 0) begin
        tests_run++;
        if (bus.wr_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s wr_ready_after_pop: got %b expected 1", tag, bus.wr_ready);
        end
      end
    end
    for (int c = 0; c < C; c++) begin
      bus.start = (c == 2);
      tick();
      bus.start = 1'b0;
      tests_run++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s compute[%0d]: valid=%b busy=%b err=%b expected 0 1 0",
                 tag, c, bus.result_valid, bus.busy, bus.err);
      end
      if (c == 0) begin
        tests_run++;
        if (bus.next_in !== 8'h00) begin
          tests_failed++;
          $display("FAIL %s next_in_after_stream: got %h expected 00", tag, bus.next_in);
        end
`ifdef OPERAND_STREAMER_CHECKSUM_EN
        tests_run++;
        if (bus.checksum !== sum) begin
          tests_failed++;
          $display("FAIL %s checksum: got %h expected %h", tag, bus.checksum, sum);
        end
`endif
      end
      if (c == C - 1) bus.f = fval;
    end
    bus.result_ready = (ready_delay == 0);
    tick();
    tests_run++;
    if (bus.result_valid !== 1'b1 || bus.result !== fval) begin
      tests_failed++;
      $display("FAIL %s result_rise: valid=%b result=%h expected 1 %h",
               tag, bus.result_valid, bus.result, fval);
    end
    bus.f = ~fval;
    if (ready_delay > 0) begin
      for (int d = 0; d < ready_delay; d++) begin
        tick();
        tests_run++;
        if (bus.result_valid !== 1'b1 || bus.result !== fval || bus.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s hold[%0d]: valid=%b result=%h busy=%b expected 1 %h 1",
                   tag, d, bus.result_valid, bus.result, bus.busy, fval);
        end
        bus.f = 8'($urandom);
      end
      bus.result_ready = 1'b1;
    end
    tick();
    bus.result_ready = 1'b0;
    tests_run++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s handshake: valid=%b busy=%b expected 0 0", tag, bus.result_valid, bus.busy);
    end
`ifdef OPERAND_STREAMER_CHECKSUM_EN
    tests_run++;
    if (bus.checksum !== sum) begin
      tests_failed++;
      $display("FAIL %s checksum_hold: got %h expected %h", tag, bus.checksum, sum);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 ||
        bus.next_in !== 8'h00 || bus.result !== 8'h00 || bus.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: wr_ready=%b busy=%b err=%b next_in=%h result=%h valid=%b expected 1 0 0 00 00 0",
               bus.wr_ready, bus.busy, bus.err, bus.next_in, bus.result, bus.result_valid);
    end
    tests_run++;
    if (bus.proc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_proc_reset: got %b expected 1", bus.proc_reset);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (bus.proc_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_proc_reset: got %b expected 0", bus.proc_reset);
    end
    model_q.delete();
    check_count("reset");
  endtask

  task automatic test_basic_run();
    for (int i = 1; i <= N; i++) push_byte(8'(i));
    do_run(8'h37, 0, 1'b0, "basic");
    check_count("basic_after");
  endtask

  task automatic test_start_error();
    for (int i = 0; i < N - 1; i++) push_byte(8'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.proc_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse: err=%b busy=%b proc_reset=%b expected 1 0 0",
               bus.err, bus.busy, bus.proc_reset);
    end
    check_count("err_untouched");
    tick();
    tests_run++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_one_cycle: err=%b busy=%b expected 0 0", bus.err, bus.busy);
    end
    push_byte(8'($urandom));
    do_run(8'($urandom), 1, 1'b0, "err_recover");
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    tests_run++;
    if (bus.wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_wr_ready: got %b expected 0", bus.wr_ready);
    end
    push_byte(8'hEE);
    check_count("full_refused");
    do_run(8'($urandom), 0, 1'b0, "full_run");
    tests_run++;
    if (bus.wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_after_run wr_ready: got %b expected 1", bus.wr_ready);
    end
    check_count("full_remaining");
  endtask

  task automatic test_hold();
    while (model_q.size() < N) push_byte(8'($urandom));
    do_run(8'hC3, 5, 1'b0, "hold");
  endtask

  task automatic test_back_to_back();
    while (model_q.size() < N) push_byte(8'($urandom));
    do_run(8'h5E, 0, 1'b1, "b2b_first");
    check_count("b2b_refilled");
    do_run(8'hA1, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_bytes[$];
    while (model_q.size() < N) push_byte(8'($urandom));
    for (int i = 0; i < N; i++) exp_bytes.push_back(model_q[i]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k <= 4; k++) tick();
    tests_run++;
    if (bus.next_in !== exp_bytes[4]) begin
      tests_failed++;
      $display("FAIL midrst_stream4: got %h expected %h", bus.next_in, exp_bytes[4]);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.proc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_proc_reset: got %b expected 1", bus.proc_reset);
    end
    tick();
    model_q.delete();
    tests_run++;
    if (bus.next_in !== 8'h00 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.wr_ready !== 1'b1 || bus.proc_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_state: next_in=%h busy=%b valid=%b wr_ready=%b proc_reset=%b expected 00 0 0 1 1",
               bus.next_in, bus.busy, bus.result_valid, bus.wr_ready, bus.proc_reset);
    end
    check_count("midrst_empty");
`ifdef OPERAND_STREAMER_CHECKSUM_EN
    tests_run++;
    if (bus.checksum !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_checksum: got %h expected 00", bus.checksum);
    end
`endif
    reset = 1'b0;
    tick();
    tests_run++;
    if (bus.proc_reset !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_release: proc_reset=%b busy=%b expected 0 0", bus.proc_reset, bus.busy);
    end
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 4; it++) begin
      int extra;
      extra = $urandom_range(0, 4);
      for (int i = 0; i < N + extra; i++) push_byte(8'($urandom));
      do_run(8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
      check_count("random_after");
    end
  endtask

`ifdef OPERAND_STREAMER_CHECKSUM_EN
  task automatic test_checksum();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q.delete();
    tick();
    for (int i = 0; i < N; i++) push_byte(8'hFF);
    do_run(8'h11, 0, 1'b0, "checksum_ff");
    tests_run++;
    if (bus.checksum !== 8'hF6) begin
      tests_failed++;
      $display("FAIL checksum_ff_value: got %h expected f6", bus.checksum);
    end
  endtask
`endif

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    bus.wr_data      = '0;
    bus.wr_valid     = 1'b0;
    bus.start        = 1'b0;
    bus.f            = '0;
    bus.result_ready = 1'b0;

    test_reset();
    test_basic_run();
    test_start_error();
    test_fifo_full();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_random_runs();
`ifdef OPERAND_STREAMER_CHECKSUM_EN
    test_checksum();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_streamer.md
# operand_streamer

Feeds the vector processor's serial operand input and collects its scalar result. A host pushes operand bytes into an internal FIFO. On `start`, the block resets the processor, streams exactly `NUM_OPERANDS` bytes on `next_in` (one per clock), waits a fixed compute latency, then captures `f` and offers it through a valid/ready result port. It sits between the host/test harness and the `top` processor instance, driving the processor's `reset` and `next_in` and consuming its `f`.

## Interface
- `DATA_W`, 8: operand/result width
- `NUM_OPERANDS`, 10: bytes streamed per run (one per processor register)
- `FIFO_DEPTH`, 16: operand FIFO entries; power of two, ≥ `NUM_OPERANDS`
- `COMPUTE_CYCLES`, 12: cycles from last streamed byte to `f` valid; ≥ 1

- `clk`  in  1: the single clock; all logic rises on it
- `reset`  in  1: synchronous, active-high
- `wr_data`  in  DATA_W: operand byte from host
- `wr_valid`  in  1: host offers `wr_data`
- `wr_ready`  out  1: FIFO not full
- `start`  in  1: run request, single-cycle pulse
- `busy`  out  1: run in progress
- `err`  out  1: one-cycle pulse, start rejected
- `proc_reset`  out  1: drives processor `reset`
- `next_in`  out  DATA_W: drives processor `next_in`
- `f`  in  DATA_W: processor result
- `result`  out  DATA_W: captured result
- `result_valid`  out  1: `result` held for host
- `result_ready`  in  1: host accepts `result`

## Operation
- FIFO write fires when `wr_valid && wr_ready`. It accepts writes in every state, including during STREAM. A simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE → PRST on `start` with count ≥ `NUM_OPERANDS`.
  - If `start` arrives with count < `NUM_OPERANDS`, stay in IDLE, pulse `err` next cycle, and leave the FIFO untouched.
  - PRST (1 cycle) → STREAM.
  - STREAM (`NUM_OPERANDS` cycles; pop one byte per cycle) → COMPUTE.
  - COMPUTE (`COMPUTE_CYCLES` cycles, down-counter) → HOLD.
  - HOLD → IDLE when `result_ready`.
- `start` outside IDLE: ignored, no `err`.
- `proc_reset = reset | (state == PRST)` (combinational).
- `next_in` is registered. In STREAM cycle k (0-based), `next_in` holds the k-th oldest FIFO byte. Outside STREAM it is 0.
- On the last COMPUTE cycle, `result <= f` and `result_valid <= 1`. `result` stays stable while `result_valid` is high. `result_valid` clears on the cycle after handshake.
- `busy` = state ≠ IDLE.
- Reset mid-run: the FSM goes to IDLE, the FIFO empties, and all registered outputs take their reset values. The processor is reset via `proc_reset`. Any partial run is discarded.

## Timing
- Reset values: `wr_ready`=1, `busy`=0, `err`=0, `next_in`=0, `result`=0, `result_valid`=0. `proc_reset`=1 while `reset` is high.
- `start` at cycle T: `proc_reset`=1 at T+1; operand 0 on `next_in` at T+2; operand N−1 at T+1+N.
- `result_valid` rises at T+2+N+`COMPUTE_CYCLES`.
- Minimum run, start to `result_valid`: 2+N+`COMPUTE_CYCLES` cycles.
- If `result_ready` is high when `result_valid` rises, the handshake completes that cycle. IDLE is next, and a new `start` is accepted the following cycle.
- FIFO full: `wr_ready`=0. If a pop happens in the same cycle, `wr_ready` reasserts on the next cycle. There is no same-cycle pass-through.
- Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Configuration
- `OPERAND_STREAMER_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_W-1:0], the modulo-2^DATA_W sum of the bytes streamed in the current/last run.
  - It clears to 0 in PRST and on reset, accumulates each STREAM cycle, and holds until the next PRST.
- Undefined: the `checksum` port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Package `streamer_pkg` holds:
  - the FSM state enum (IDLE, PRST, STREAM, COMPUTE, HOLD);
  - default widths `DATA_W`/`NUM_OPERANDS` as localparams.
- Sub-module `sync_fifo` (parameters `DATA_W`, `DEPTH`) provides push/pop/full/empty/count and first-word data visible at output.
- The top-level `operand_streamer` holds the FSM, the stream/compute counters, and the result register.

## Test plan
- Push 10 bytes 0x01..0x0A, `start` → `proc_reset` one cycle, then `next_in` = 0x01..0x0A on consecutive cycles. With `f` forced to 0x37, `result`=0x37 and `result_valid` appear 24 cycles after `start`.
- Push 9 bytes, `start` → `err` pulse one cycle later, `busy` stays 0, FIFO count stays 9. Push a 10th byte and `start` → a normal run.
- Push 16 bytes → `wr_ready`=0 with the 17th write refused. Run → first 10 bytes streamed, 6 remain, `wr_ready`=1.
- Hold `result_ready`=0 for 5 cycles in HOLD while `f` changes → `result` stable. `result_ready`=1 → `result_valid` drops next cycle and a new run is accepted.
- Assert `reset` in STREAM cycle 4 → `next_in`=0, `busy`=0, FIFO empty next cycle, `proc_reset` high during reset.
- With `OPERAND_STREAMER_CHECKSUM_EN`: stream 10 bytes of 0xFF → `checksum`=0xF6.
